// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, FIFO entry layout, PC helpers.
package fetch_queue_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fq_state_t;

   localparam int          INST_W = 32;
   localparam logic [31:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, inst}; head is visible one cycle after push.
// Push and pop may coincide at any occupancy; flush empties it on the next edge.
module fetch_fifo
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  fetch_entry_t push_dat,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head_dat,
   output logic [CW-1:0] count,
   output logic         full,
   output logic         empty
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   // Empty head reads as zero so the outputs are defined before the first write.
   assign head_dat = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: issues word requests, buffers tagged responses, redirect flushes and drains stale replies.
// Output visible 1 cycle after response; requests throttled by MAX_OUT and FIFO credit.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter int          MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        IFreq_valid,
   input  logic        IFreq_ready,
   output logic [31:0] IFreq_addr,
   input  logic        IFrsp_valid,
   input  logic [31:0] IFrsp_data,
   output logic        IFinst_valid,
   input  logic        IFinst_ready,
   output logic [31:0] IFinst,
   output logic [31:0] IFpc,
   input  logic        IFredirect,
   input  logic [31:0] IFredirect_pc
);

   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int CW = $clog2(DEPTH + 1);

   fq_state_t     state;
   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [OW-1:0] o_cnt;
   logic [OW-1:0] d_cnt;
   logic [OW-1:0] o_next;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fire;
   logic [31:0]   in_use;
   fetch_entry_t  head;
   fetch_entry_t  push_dat;

   // Stale requests (d_cnt) will be dropped, so they do not hold FIFO credit.
   assign in_use      = 32'(fifo_count) + 32'(o_cnt) - 32'(d_cnt);
   assign IFreq_valid = (state != IDLE) && (32'(o_cnt) < 32'(MAX_OUT)) && (in_use < 32'(DEPTH));
   assign IFreq_addr  = fetch_pc;
   assign fire        = IFreq_valid && IFreq_ready;
   assign o_next      = o_cnt + OW'(fire) - OW'(IFrsp_valid);

   assign fifo_push   = IFrsp_valid && !IFredirect && (d_cnt == '0);
   assign fifo_pop    = IFinst_valid && IFinst_ready;
   assign push_dat    = '{pc: rsp_pc, inst: IFrsp_data};

   assign IFinst_valid = !fifo_empty;
   assign IFinst       = head.inst;
   assign IFpc         = head.pc;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifo_push),
      .push_dat (push_dat),
      .pop      (fifo_pop),
      .flush    (IFredirect),
      .head_dat (head),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         o_cnt    <= '0;
         d_cnt    <= '0;
      end else begin
         o_cnt <= o_next;
         if (IFredirect) begin
            // Everything still outstanding after this edge, including a same-cycle fire, is stale.
            fetch_pc <= align_pc(IFredirect_pc);
            rsp_pc   <= align_pc(IFredirect_pc);
            d_cnt    <= o_next;
         end else begin
            if (fire)      fetch_pc <= fetch_pc + PC_INC;
            if (fifo_push) rsp_pc   <= rsp_pc + PC_INC;
            if (IFrsp_valid && (d_cnt != '0)) d_cnt <= d_cnt - OW'(1);
         end
         case (state)
            IDLE:  state <= RUN;
            RUN:   if (IFredirect && (o_next != '0)) state <= DRAIN;
            DRAIN: begin
               if (IFredirect)
                  state <= (o_next != '0) ? DRAIN : RUN;
               else if (IFrsp_valid && (d_cnt == OW'(1)))
                  state <= RUN;
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_rsp_with_outstanding: assert property (@(posedge clk) disable iff (reset)
      IFrsp_valid |-> (o_cnt != '0));
   a_no_push_full: assert property (@(posedge clk) disable iff (reset)
      fifo_push |-> !fifo_full);

endmodule
